// File: rtl/ddr3_tester_pkg.sv
// ddr3_tester_pkg: shared types and helpers for the DDR3 pattern tester.
//   state_t      - tester FSM states
//   WORD_BYTES   - bytes per 128-bit user word (address step)
//   LANE_W       - width of one 32-bit pattern lane
//   pattern_lane - data pattern for one lane, used for both write and compare
package ddr3_tester_pkg;
  localparam int WORD_BYTES = 16;
  localparam int LANE_W     = 32;
  localparam int NUM_LANES  = 4;
  localparam int IDX_W      = 22;   // word index bits carried in the pattern
  localparam int ADDR_W     = 30;
  localparam int DATA_W     = NUM_LANES * LANE_W;

  typedef enum logic [2:0] {
    IDLE, WR_CMD, WR_DATA, WR_WAIT, RD_CMD, RD_DATA, RD_WAIT, PASS_END
  } state_t;

  // Lane i of word w in pass p = {p[7:0], w[21:0], i[1:0]}
  function automatic logic [LANE_W-1:0] pattern_lane(input logic [7:0]       pass_lo,
                                                     input logic [IDX_W-1:0] word_idx,
                                                     input logic [1:0]       lane);
    return {pass_lo, word_idx, lane};
  endfunction
endpackage

// File: rtl/ddr3_pattern_tester_if.sv
// ddr3_pattern_tester_if: user write/read port of DDR3_User_Design.
//   master - the traffic generator (drives commands, write data, read pops)
//   slave  - the DDR3 user design (drives ready/done and read data)
interface ddr3_pattern_tester_if;
  import ddr3_tester_pkg::*;
  logic              u_wr_cmd_en;
  logic [ADDR_W-1:0] u_wr_addr;
  logic [6:0]        u_wr_len;
  logic              u_wr_en;
  logic [DATA_W-1:0] u_wr_data;
  logic              u_wr_rdy;
  logic              u_wr_cmd_done;
  logic              u_rd_cmd_en;
  logic [ADDR_W-1:0] u_rd_addr;
  logic [6:0]        u_rd_len;
  logic              u_rd_en;
  logic [DATA_W-1:0] u_rd_data;
  logic              u_rd_rdy;
  logic              u_rd_cmd_done;

  modport master (
    output u_wr_cmd_en, u_wr_addr, u_wr_len, u_wr_en, u_wr_data,
    output u_rd_cmd_en, u_rd_addr, u_rd_len, u_rd_en,
    input  u_wr_rdy, u_wr_cmd_done, u_rd_data, u_rd_rdy, u_rd_cmd_done
  );
  modport slave (
    input  u_wr_cmd_en, u_wr_addr, u_wr_len, u_wr_en, u_wr_data,
    input  u_rd_cmd_en, u_rd_addr, u_rd_len, u_rd_en,
    output u_wr_rdy, u_wr_cmd_done, u_rd_data, u_rd_rdy, u_rd_cmd_done
  );
endinterface

// File: rtl/ddr3_pattern_gen.sv
// ddr3_pattern_gen: combinational 128-bit test pattern.
//   pass_lo  - low byte of the pass counter
//   word_idx - word offset from the region start
//   pattern  - four 32-bit lanes, lane 0 in bits 31:0
module ddr3_pattern_gen
  import ddr3_tester_pkg::*;
(
  input  logic [7:0]                         pass_lo,
  input  logic [IDX_W-1:0]                   word_idx,
  output logic [NUM_LANES-1:0][LANE_W-1:0]   pattern
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign pattern[i] = pattern_lane(pass_lo, word_idx, 2'(i));
  end
endmodule

// File: rtl/ddr3_pattern_tester.sv
// ddr3_pattern_tester: writes a deterministic pattern over a DDR3 region,
// reads it back and compares every word, pass after pass while start=1.
//   clk, rst_n     - user clock, async active-low reset
//   start          - run enable, sampled in IDLE and at the end of a pass
//   u              - user write/read port toward DDR3_User_Design
//   busy           - FSM not idle
//   pass_done      - one-cycle pulse per completed pass
//   pass_cnt       - completed passes (wraps)
//   err_cnt        - mismatching words (saturates)
//   error          - sticky mismatch flag
//   first_err_addr - byte address of the first mismatch
module ddr3_pattern_tester
  import ddr3_tester_pkg::*;
#(
  parameter int                BURST_LEN  = 32,
  parameter int                NUM_BURSTS = 64,
  parameter logic [ADDR_W-1:0] START_ADDR = 30'h0
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  ddr3_pattern_tester_if.master u,
  output logic                 busy,
  output logic                 pass_done,
  output logic [15:0]          pass_cnt,
  output logic [15:0]          err_cnt,
  output logic                 error,
  output logic [ADDR_W-1:0]    first_err_addr
);
  localparam int BW   = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int IW   = ADDR_W - $clog2(WORD_BYTES);   // word index spanning the byte address
  localparam logic [6:0]    LAST_BEAT  = 7'(BURST_LEN - 1);
  localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);

  state_t state, state_nxt;
  logic [BW-1:0]     burst;
  logic [6:0]        beat;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic              done_seen;    // done pulse that arrived during the DATA state
  logic              wr_acc, rd_acc, wr_last, rd_last, burst_last, wr_done_any, rd_done_any;
  logic [DATA_W-1:0] wr_pat, cmp_pat;

  ddr3_pattern_gen u_wr_gen  (.pass_lo(pass_cnt[7:0]), .word_idx(wr_idx[IDX_W-1:0]), .pattern(wr_pat));
  ddr3_pattern_gen u_cmp_gen (.pass_lo(pass_cnt[7:0]), .word_idx(rd_idx[IDX_W-1:0]), .pattern(cmp_pat));

  assign wr_acc      = u.u_wr_en && u.u_wr_rdy;
  assign rd_acc      = u.u_rd_en;
  assign wr_last     = wr_acc && (beat == LAST_BEAT);
  assign rd_last     = rd_acc && (beat == LAST_BEAT);
  assign burst_last  = (burst == LAST_BURST);
  assign wr_done_any = u.u_wr_cmd_done || done_seen;
  assign rd_done_any = u.u_rd_cmd_done || done_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = WR_CMD;
      WR_CMD:   state_nxt = WR_DATA;
      WR_DATA:  if (wr_last) state_nxt = WR_WAIT;
      WR_WAIT:  if (wr_done_any) state_nxt = burst_last ? RD_CMD : WR_CMD;
      RD_CMD:   state_nxt = RD_DATA;
      RD_DATA:  if (rd_last) state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_done_any) state_nxt = burst_last ? PASS_END : RD_CMD;
      PASS_END: state_nxt = start ? WR_CMD : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Write data is gated so the bus reads zero outside a write burst; within
  // the burst it only moves when a word is accepted, so stalls hold it.
  always_comb begin
    u.u_wr_en   = (state == WR_DATA);
    u.u_rd_en   = (state == RD_DATA) && u.u_rd_rdy;
    u.u_wr_data = (state == WR_DATA) ? wr_pat : '0;
    busy        = (state != IDLE);
    pass_done   = (state == PASS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u.u_wr_cmd_en  <= 1'b0;
      u.u_wr_addr    <= '0;
      u.u_wr_len     <= '0;
      u.u_rd_cmd_en  <= 1'b0;
      u.u_rd_addr    <= '0;
      u.u_rd_len     <= '0;
      burst          <= '0;
      beat           <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      done_seen      <= 1'b0;
      pass_cnt       <= '0;
      err_cnt        <= '0;
      error          <= 1'b0;
      first_err_addr <= '0;
    end else begin
      // Command strobes are registered: they rise the cycle after the CMD state.
      u.u_wr_cmd_en <= (state == WR_CMD);
      u.u_rd_cmd_en <= (state == RD_CMD);
      case (state)
        IDLE, PASS_END: begin
          burst     <= '0;
          beat      <= '0;
          wr_idx    <= '0;
          rd_idx    <= '0;
          done_seen <= 1'b0;
          if (state == PASS_END) pass_cnt <= pass_cnt + 16'd1;
        end
        WR_CMD: begin
          u.u_wr_addr <= START_ADDR + ADDR_W'(wr_idx) * ADDR_W'(WORD_BYTES);
          u.u_wr_len  <= 7'(BURST_LEN);
        end
        WR_DATA: begin
          if (u.u_wr_cmd_done) done_seen <= 1'b1;
          if (wr_acc) begin
            wr_idx <= wr_idx + 1'b1;
            beat   <= wr_last ? '0 : beat + 7'd1;
          end
        end
        RD_CMD: begin
          u.u_rd_addr <= START_ADDR + ADDR_W'(rd_idx) * ADDR_W'(WORD_BYTES);
          u.u_rd_len  <= 7'(BURST_LEN);
        end
        RD_DATA: begin
          if (u.u_rd_cmd_done) done_seen <= 1'b1;
          if (rd_acc) begin
            rd_idx <= rd_idx + 1'b1;
            beat   <= rd_last ? '0 : beat + 7'd1;
          end
        end
        WR_WAIT, RD_WAIT: begin
          if ((state == WR_WAIT) ? wr_done_any : rd_done_any) begin
            done_seen <= 1'b0;
            burst     <= burst_last ? '0 : burst + 1'b1;
          end
        end
        default: ;
      endcase
      if (rd_acc && (u.u_rd_data != cmp_pat)) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (!error) begin
          error          <= 1'b1;
          first_err_addr <= START_ADDR + ADDR_W'(rd_idx) * ADDR_W'(WORD_BYTES);
        end
      end
    end
  end
endmodule

// File: tb/tb_ddr3_pattern_tester.sv
`timescale 1ns/1ps
module tb_ddr3_pattern_tester;
  localparam int BL    = 4;
  localparam int NB    = 2;
  localparam int WORDS = BL * NB;
  localparam logic [29:0] SA = 30'h0;

  typedef struct { logic rd; logic [29:0] addr; logic [6:0] len; } cmd_exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, pass_done, error;
  logic [15:0] pass_cnt, err_cnt;
  logic [29:0] first_err_addr;

  ddr3_pattern_tester_if bus();

  ddr3_pattern_tester #(.BURST_LEN(BL), .NUM_BURSTS(NB), .START_ADDR(SA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .u(bus.master),
    .busy(busy), .pass_done(pass_done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .error(error), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_done = 0, m_pass = 0;
  logic [127:0] q_wr[$];
  cmd_exp_t     q_cmd[$];
  int           q_pass[$];
  logic [127:0] mem [logic [29:0]];
  int           stall_req = 0;
  bit           rd_done_now = 0, flip_arm = 0;
  int           exp_err = 0;
  bit           exp_error = 0;
  logic [29:0]  exp_first = '0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pattern straight from the arithmetic definition of each lane.
  function automatic logic [127:0] model_pat(int p, int idx);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      w[i*32 +: 32] = 32'(longint'(p % 256) * 64'd16777216 + longint'(idx % 4194304) * 4 + i);
    return w;
  endfunction

  task automatic push_pass();
    for (int b = 0; b < NB; b++) q_cmd.push_back('{1'b0, SA + 30'(b*BL*16), 7'(BL)});
    for (int b = 0; b < NB; b++) q_cmd.push_back('{1'b1, SA + 30'(b*BL*16), 7'(BL)});
    for (int i = 0; i < WORDS; i++) q_wr.push_back(model_pat(m_pass, i));
    q_pass.push_back(m_pass);
    m_pass++;
  endtask

  // Loopback DDR model: drives inputs at negedge, seen by the DUT at the next posedge.
  initial begin : slave
    logic [29:0] wp, rp;
    int wl, rl, wd, rdl;
    wp = '0; rp = '0; wl = 0; rl = 0; wd = -1; rdl = -1;
    bus.u_wr_rdy = 0; bus.u_wr_cmd_done = 0; bus.u_rd_rdy = 0;
    bus.u_rd_data = '0; bus.u_rd_cmd_done = 0;
    forever begin
      @(negedge clk);
      bus.u_wr_cmd_done = 0; bus.u_rd_cmd_done = 0; bus.u_rd_rdy = 0;
      if (!rst_n) begin
        wl = 0; rl = 0; wd = -1; rdl = -1; bus.u_wr_rdy = 0;
        continue;
      end
      if (bus.u_wr_cmd_en) begin wp = bus.u_wr_addr; wl = int'(bus.u_wr_len); end
      if (bus.u_rd_cmd_en) begin rp = bus.u_rd_addr; rl = int'(bus.u_rd_len); end
      if (stall_req > 0) begin bus.u_wr_rdy = 0; stall_req--; end
      else bus.u_wr_rdy = ($urandom_range(0, 3) != 0);
      if (bus.u_wr_en && bus.u_wr_rdy && wl > 0) begin
        mem[wp] = bus.u_wr_data; wp += 30'd16; wl--;
        if (wl == 0) wd = $urandom_range(0, 2);
      end
      if (wd == 0) bus.u_wr_cmd_done = 1;
      if (wd >= 0) wd--;
      if (rl > 0 && $urandom_range(0, 3) != 0) begin
        bus.u_rd_rdy  = 1;
        bus.u_rd_data = mem.exists(rp) ? mem[rp] : '0;
        if (flip_arm && rp == 30'h30) bus.u_rd_data[0] = ~bus.u_rd_data[0];
      end
      #1;
      if (bus.u_rd_en) begin
        if (flip_arm && rp == 30'h30) begin
          exp_err++;
          if (!exp_error) begin exp_error = 1; exp_first = rp; end
        end
        rp += 30'd16; rl--;
        if (rl == 0) rdl = rd_done_now ? 0 : $urandom_range(0, 2);
      end
      if (rdl == 0) bus.u_rd_cmd_done = 1;
      if (rdl >= 0) rdl--;
    end
  end

  // Monitor: pops expectations as the DUT presents commands, write words and pass ends.
  initial begin : monitor
    logic [127:0] prev_data;
    bit prev_stall;
    cmd_exp_t c;
    prev_data = '0; prev_stall = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin prev_stall = 0; continue; end
      if (bus.u_wr_cmd_en || bus.u_rd_cmd_en) begin
        if (q_cmd.size() == 0) check("unexpected_cmd", 1, 0);
        else begin
          c = q_cmd.pop_front();
          check("cmd_kind", bus.u_rd_cmd_en, c.rd);
          check("cmd_addr", c.rd ? bus.u_rd_addr : bus.u_wr_addr, c.addr);
          check("cmd_len", c.rd ? bus.u_rd_len : bus.u_wr_len, c.len);
        end
      end
      if (bus.u_wr_en && prev_stall) check("wr_data_hold", bus.u_wr_data, prev_data);
      if (bus.u_wr_en && bus.u_wr_rdy) begin
        if (q_wr.size() == 0) check("unexpected_wr", 1, 0);
        else check("wr_data", bus.u_wr_data, q_wr.pop_front());
      end
      prev_stall = bus.u_wr_en && !bus.u_wr_rdy;
      prev_data  = bus.u_wr_data;
      if (pass_done) begin
        n_done++;
        if (q_pass.size() == 0) check("unexpected_pass", 1, 0);
        else check("pass_cnt_at_done", pass_cnt, q_pass.pop_front());
        check("pass_err_cnt", err_cnt, exp_err);
        check("pass_error", error, exp_error);
        check("pass_first_err", first_err_addr, exp_first);
        check("pass_drained", q_wr.size() + q_cmd.size(), 0);
        if (start) push_pass();
      end
    end
  end

  task automatic wait_done(int target);
    int c = 0;
    while (n_done < target && c < 600) begin @(negedge clk); c++; end
    #3;
    check("wait_pass_done", n_done >= target, 1);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pass_done"}, pass_done, 0);
    check({tag, "_pass_cnt"}, pass_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_first_err"}, first_err_addr, 0);
    check({tag, "_wr_ctl"}, {bus.u_wr_cmd_en, bus.u_wr_en, bus.u_wr_addr, bus.u_wr_len}, 0);
    check({tag, "_wr_data"}, bus.u_wr_data, 0);
    check({tag, "_rd_ctl"}, {bus.u_rd_cmd_en, bus.u_rd_en, bus.u_rd_addr, bus.u_rd_len}, 0);
  endtask

  initial begin : stim
    int c;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk); #3;
    check("idle_busy", busy, 0);
    check("idle_no_cmd", bus.u_wr_cmd_en, 0);

    // Pass 0: clean loopback; pass 1 then sees a corrupted word at 0x30.
    @(negedge clk); push_pass(); start = 1;
    wait_done(1);
    check("word5_pass0", mem.exists(30'h50) ? mem[30'h50] : 128'h0,
          128'h00000017_00000016_00000015_00000014);
    check("pass0_err_cnt", err_cnt, 0);
    flip_arm = 1;
    wait_done(2);
    flip_arm = 0;
    check("flip_error", error, 1);
    check("flip_err_cnt", err_cnt, 1);
    check("flip_first_addr", first_err_addr, 30'h30);

    // Pass 2: three-cycle write stall inside a burst.
    c = 0;
    do begin @(negedge clk); #3; c++; end while (!bus.u_wr_en && c < 100);
    check("stall_reached_wr", bus.u_wr_en, 1);
    stall_req = 3;
    wait_done(3);

    // Pass 3: read done lands on the last read word.
    rd_done_now = 1;
    wait_done(4);
    rd_done_now = 0;

    // Pass 4: start dropped during the read phase.
    c = 0;
    do begin @(negedge clk); #3; c++; end while (!bus.u_rd_cmd_en && c < 200);
    check("reached_rd_phase", bus.u_rd_cmd_en, 1);
    @(negedge clk); start = 0;
    wait_done(5);
    repeat (3) @(negedge clk); #3;
    check("stop_busy", busy, 0);
    check("stop_pass_cnt", pass_cnt, 5);
    repeat (10) @(negedge clk); #3;
    check("stop_still_idle", busy, 0);

    // Pass 5: reset in the middle of a write burst.
    @(negedge clk); push_pass(); start = 1;
    c = 0;
    do begin @(negedge clk); #3; c++; end while (!(bus.u_wr_en && q_wr.size() <= WORDS - 3) && c < 200);
    check("reached_wr_data", bus.u_wr_en, 1);
    rst_n = 0;
    #1 check_all_zero("async_rst");
    q_wr.delete(); q_cmd.delete(); q_pass.delete();
    m_pass = 0; exp_err = 0; exp_error = 0; exp_first = '0;
    repeat (2) @(negedge clk);
    push_pass(); rst_n = 1;
    @(negedge clk); start = 0;
    wait_done(6);
    repeat (3) @(negedge clk); #3;
    check("restart_pass_cnt", pass_cnt, 1);
    check("restart_err_cnt", err_cnt, 0);
    check("restart_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: run did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
